// File: rtl/alarm_trigger_if.sv
// alarm_trigger_if
// Bundles the time inputs, user controls and status outputs of alarm_trigger.
//   master : drives SEC_TICK, CUR_*, ALM_*, ARM, ACK, SNOOZE; observes status
//   slave  : the alarm_trigger side (consumes controls, drives status)
// Status signals: ALARM, BEEP, STATE[1:0], SNOOZE_CNT[1:0], MISSED.
interface alarm_trigger_if;
  logic       SEC_TICK;
  logic [7:0] CUR_SEC;
  logic [7:0] CUR_MIN;
  logic [7:0] CUR_HR;
  logic [7:0] ALM_SEC;
  logic [7:0] ALM_MIN;
  logic [7:0] ALM_HR;
  logic       ARM;
  logic       ACK;
  logic       SNOOZE;
  logic       ALARM;
  logic       BEEP;
  logic [1:0] STATE;
  logic [1:0] SNOOZE_CNT;
  logic       MISSED;

  modport master (
    output SEC_TICK, CUR_SEC, CUR_MIN, CUR_HR, ALM_SEC, ALM_MIN, ALM_HR,
           ARM, ACK, SNOOZE,
    input  ALARM, BEEP, STATE, SNOOZE_CNT, MISSED
  );

  modport slave (
    input  SEC_TICK, CUR_SEC, CUR_MIN, CUR_HR, ALM_SEC, ALM_MIN, ALM_HR,
           ARM, ACK, SNOOZE,
    output ALARM, BEEP, STATE, SNOOZE_CNT, MISSED
  );
endinterface

// File: rtl/alarm_trigger.sv
// alarm_trigger
// Alarm-clock trigger FSM: compares the current time against the alarm (or a
// snooze) target, rings with a 1 Hz buzzer toggle, and handles dismiss,
// snooze and ring timeout.
// Ports:
//   CLK   - system clock, rising edge
//   RESET - synchronous, active-low reset
//   bus   - alarm_trigger_if.slave: SEC_TICK, CUR_*, ALM_*, ARM, ACK, SNOOZE in;
//           ALARM, BEEP, STATE, SNOOZE_CNT, MISSED out (all registered)
// Parameters: SNOOZE_MIN (1..59), RING_TIMEOUT (1..255), MAX_SNOOZE (1..3).
// Build option: define ALARM_TRIGGER_SNOOZE_EN to include the snooze logic;
// without it SNOOZE is ignored, SNOOZED is unreachable and SNOOZE_CNT is 0.
module alarm_trigger #(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic           CLK,
  input  logic           RESET,
  alarm_trigger_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RINGING = 2'b10,
    SNOOZED = 2'b11
  } state_t;

  localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT - 1);

  state_t     state;
  logic       alarm_q;
  logic       beep_q;
  logic       missed_q;
  logic       prev_eq;
  logic [7:0] ring_cnt;
  logic [1:0] snz_cnt;
  logic [7:0] tgt_sec;
  logic [7:0] tgt_min;
  logic [7:0] tgt_hr;
  logic       cur_eq;
  logic       match;
  logic       snooze_take;

`ifdef ALARM_TRIGGER_SNOOZE_EN
  localparam logic [7:0] SNZ_MIN = 8'(SNOOZE_MIN);
  localparam logic [1:0] SNZ_MAX = 2'(MAX_SNOOZE);

  logic [7:0] snz_sec;
  logic [7:0] snz_min;
  logic [7:0] snz_hr;
  logic [7:0] nxt_sec;
  logic [7:0] nxt_min;
  logic [7:0] nxt_hr;
  logic [7:0] min_sum;

  // Snooze target = now + SNOOZE_MIN minutes, with minute->hour carry and
  // midnight wrap. Seconds are kept so the re-ring lands on the same second.
  always_comb begin
    min_sum = bus.CUR_MIN + SNZ_MIN;
    nxt_sec = bus.CUR_SEC;
    nxt_min = min_sum;
    nxt_hr  = bus.CUR_HR;
    if (min_sum >= 8'd60) begin
      nxt_min = min_sum - 8'd60;
      nxt_hr  = (bus.CUR_HR >= 8'd23) ? 8'd0 : bus.CUR_HR + 8'd1;
    end
  end

  // A snooze is only honoured while ringing, not overridden by ACK or disarm,
  // and while the per-event budget is not exhausted.
  assign snooze_take = (state == RINGING) && bus.ARM && !bus.ACK &&
                       bus.SNOOZE && (snz_cnt < SNZ_MAX);

  // Snooze target is captured once per snooze, so later ALM_* edits do not
  // move it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      snz_sec <= '0;
      snz_min <= '0;
      snz_hr  <= '0;
    end else if (snooze_take) begin
      snz_sec <= nxt_sec;
      snz_min <= nxt_min;
      snz_hr  <= nxt_hr;
    end
  end

  // While snoozed we wait on the captured target; otherwise track ALM_* live.
  always_comb begin
    tgt_sec = bus.ALM_SEC;
    tgt_min = bus.ALM_MIN;
    tgt_hr  = bus.ALM_HR;
    if (state == SNOOZED) begin
      tgt_sec = snz_sec;
      tgt_min = snz_min;
      tgt_hr  = snz_hr;
    end
  end

  assign bus.SNOOZE_CNT = snz_cnt;
`else
  assign snooze_take = 1'b0;
  assign tgt_sec     = bus.ALM_SEC;
  assign tgt_min     = bus.ALM_MIN;
  assign tgt_hr      = bus.ALM_HR;
  assign bus.SNOOZE_CNT = 2'b00;

  // Snooze input, counter and snooze parameters have no function in this build.
  logic unused_snooze;
  assign unused_snooze = bus.SNOOZE ^ (|snz_cnt) ^
                         (SNOOZE_MIN == 0) ^ (MAX_SNOOZE == 0);
`endif

  // Match is the rising edge of equality, so a time held for a whole second
  // fires only once.
  assign cur_eq = (bus.CUR_SEC == tgt_sec) && (bus.CUR_MIN == tgt_min) &&
                  (bus.CUR_HR == tgt_hr);
  assign match  = cur_eq && !prev_eq;

  // Main FSM with all outputs registered. Disarm beats everything except
  // reset; in RINGING, ACK beats SNOOZE, which beats the timeout tick.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      alarm_q  <= 1'b0;
      beep_q   <= 1'b0;
      missed_q <= 1'b0;
      snz_cnt  <= 2'd0;
      ring_cnt <= 8'd0;
      prev_eq  <= 1'b1;
    end else begin
      prev_eq <= cur_eq;
      if (!bus.ARM) begin
        state    <= IDLE;
        alarm_q  <= 1'b0;
        beep_q   <= 1'b0;
        snz_cnt  <= 2'd0;
        ring_cnt <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARMED;
          end
          ARMED: begin
            if (bus.ACK) begin
              missed_q <= 1'b0;
            end
            if (match) begin
              state    <= RINGING;
              alarm_q  <= 1'b1;
              beep_q   <= 1'b1;
              ring_cnt <= 8'd0;
            end
          end
          RINGING: begin
            if (bus.ACK) begin
              state    <= ARMED;
              alarm_q  <= 1'b0;
              beep_q   <= 1'b0;
              ring_cnt <= 8'd0;
              snz_cnt  <= 2'd0;
              missed_q <= 1'b0;
            end else if (snooze_take) begin
              state    <= SNOOZED;
              alarm_q  <= 1'b0;
              beep_q   <= 1'b0;
              ring_cnt <= 8'd0;
              snz_cnt  <= snz_cnt + 2'd1;
            end else if (bus.SEC_TICK) begin
              if (ring_cnt == RING_LAST) begin
                state    <= ARMED;
                alarm_q  <= 1'b0;
                beep_q   <= 1'b0;
                ring_cnt <= 8'd0;
                snz_cnt  <= 2'd0;
                missed_q <= 1'b1;
              end else begin
                ring_cnt <= ring_cnt + 8'd1;
                beep_q   <= !beep_q;
              end
            end
          end
          SNOOZED: begin
            if (bus.ACK) begin
              state    <= ARMED;
              snz_cnt  <= 2'd0;
              missed_q <= 1'b0;
            end else if (match) begin
              state    <= RINGING;
              alarm_q  <= 1'b1;
              beep_q   <= 1'b1;
              ring_cnt <= 8'd0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.STATE  = state;
  assign bus.ALARM  = alarm_q;
  assign bus.BEEP   = beep_q;
  assign bus.MISSED = missed_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger
// Directed scenarios for alarm_trigger: reset, arm, ring/beep, dismiss without
// re-trigger, ring timeout with MISSED, reset and disarm mid-ring, and either
// the snooze chain (ALARM_TRIGGER_SNOOZE_EN defined) or snooze being ignored.
module tb_alarm_trigger;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_RING  = 2'b10;
  localparam logic [1:0] S_SNZ   = 2'b11;

  typedef struct {
    string      name;
    int         due;
    logic [1:0] st;
    logic       al;
    logic       bp;
    logic [1:0] sc;
    logic       ms;
  } exp_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  alarm_trigger_if bus ();

  alarm_trigger #(
    .SNOOZE_MIN  (5),
    .RING_TIMEOUT(60),
    .MAX_SNOOZE  (3)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  exp_t        sbq[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic        done   = 1'b0;
  logic [23:0] alm_t  = '0;

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {8'(h), 8'(m), 8'(s)};
  endfunction

  // Drive one cycle of inputs at the falling edge; alarm time comes from alm_t.
  task automatic applyStimulus(input logic rstn, input logic tick, input logic arm,
                               input logic ack, input logic snz, input logic [23:0] cur);
    @(negedge CLK);
    RESET        = rstn;
    bus.SEC_TICK = tick;
    bus.ARM      = arm;
    bus.ACK      = ack;
    bus.SNOOZE   = snz;
    {bus.CUR_HR, bus.CUR_MIN, bus.CUR_SEC} = cur;
    {bus.ALM_HR, bus.ALM_MIN, bus.ALM_SEC} = alm_t;
  endtask

  // Queue the response expected after the edge that follows the last stimulus.
  task automatic checkOutput(input string name, input logic [1:0] st, input logic al,
                             input logic bp, input logic [1:0] sc, input logic ms);
    exp_t e;
    e.name = name;
    e.due  = cyc + 1;
    e.st   = st;
    e.al   = al;
    e.bp   = bp;
    e.sc   = sc;
    e.ms   = ms;
    sbq.push_back(e);
  endtask

  // Monitor: a little after each rising edge, compare every due expectation.
  always @(posedge CLK) begin : monitor
    exp_t       e;
    logic [6:0] act;
    logic [6:0] req;
    #2;
    cyc = cyc + 1;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e   = sbq.pop_front();
      act = {bus.STATE, bus.ALARM, bus.BEEP, bus.SNOOZE_CNT, bus.MISSED};
      req = {e.st, e.al, e.bp, e.sc, e.ms};
      checks = checks + 1;
      if (act !== req) begin
        errors = errors + 1;
        $display("[TB] FAIL %s: got state=%b alarm=%b beep=%b snooze_cnt=%0d missed=%b, expected state=%b alarm=%b beep=%b snooze_cnt=%0d missed=%b",
                 e.name, act[6:5], act[4], act[3], act[2:1], act[0],
                 req[6:5], req[4], req[3], req[2:1], req[0]);
      end
    end
    if (done) begin
      checks = checks + 1;
      if (sbq.size() != 0) begin
        errors = errors + 1;
        $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    bus.SEC_TICK = 1'b0;
    bus.ARM      = 1'b0;
    bus.ACK      = 1'b0;
    bus.SNOOZE   = 1'b0;
    {bus.CUR_HR, bus.CUR_MIN, bus.CUR_SEC} = hms(6, 59, 58);
    alm_t = hms(7, 0, 0);
    {bus.ALM_HR, bus.ALM_MIN, bus.ALM_SEC} = alm_t;

    $display("[TB] start");

    // Reset, arm, ring at 07:00:00 and dismiss within the same second.
    applyStimulus(0, 0, 0, 0, 0, hms(6, 59, 58));
    checkOutput("reset", S_IDLE, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, hms(6, 59, 58));
    checkOutput("arm", S_ARMED, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(6, 59, 59));
    checkOutput("armed_wait", S_ARMED, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(7, 0, 0));
    checkOutput("ring_entry", S_RING, 1, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, hms(7, 0, 0));
    checkOutput("ring_hold", S_RING, 1, 1, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, hms(7, 0, 0));
    checkOutput("ack", S_ARMED, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0, 0, hms(7, 0, 0));
      checkOutput("no_retrigger", S_ARMED, 0, 0, 0, 0);
    end

    // Ring at 07:00:03, watch BEEP toggle, then let it time out.
    alm_t = hms(7, 0, 3);
    applyStimulus(1, 1, 1, 0, 0, hms(7, 0, 1));
    applyStimulus(1, 1, 1, 0, 0, hms(7, 0, 2));
    applyStimulus(1, 1, 1, 0, 0, hms(7, 0, 3));
    checkOutput("ring2_entry", S_RING, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(7, 0, 4));
    checkOutput("beep_tick1", S_RING, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, hms(7, 0, 4));
    checkOutput("beep_no_tick", S_RING, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(7, 0, 5));
    checkOutput("beep_tick2", S_RING, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(7, 0, 6));
    checkOutput("beep_tick3", S_RING, 1, 0, 0, 0);
    for (int i = 4; i < 60; i++) begin
      applyStimulus(1, 1, 1, 0, 0, hms(7, 1, 0));
    end
    checkOutput("pre_timeout", S_RING, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(7, 1, 0));
    checkOutput("timeout", S_ARMED, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0, hms(7, 1, 0));
    checkOutput("missed_sticky", S_ARMED, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 1, 0, hms(7, 1, 0));
    checkOutput("ack_clears_missed", S_ARMED, 0, 0, 0, 0);

    // Reset mid-ring wins over tick and ARM; no spurious match afterwards.
    alm_t = hms(8, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, hms(7, 59, 59));
    applyStimulus(1, 0, 1, 0, 0, hms(8, 0, 0));
    checkOutput("ring3_entry", S_RING, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(8, 0, 1));
    checkOutput("ring3_tick", S_RING, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, hms(8, 0, 0));
    checkOutput("reset_midring", S_IDLE, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, hms(8, 0, 0));
    checkOutput("rearm", S_ARMED, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, hms(8, 0, 0));
    checkOutput("no_spurious", S_ARMED, 0, 0, 0, 0);

    // Disarm while ringing.
    alm_t = hms(9, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, hms(8, 59, 59));
    applyStimulus(1, 0, 1, 0, 0, hms(9, 0, 0));
    checkOutput("ring4_entry", S_RING, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, hms(9, 0, 0));
    checkOutput("disarm_ring", S_IDLE, 0, 0, 0, 0);

    // Ring just before midnight, then exercise snooze.
    alm_t = hms(23, 58, 10);
    applyStimulus(1, 0, 1, 0, 0, hms(23, 58, 9));
    checkOutput("rearm2", S_ARMED, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(23, 58, 10));
    checkOutput("ring5_entry", S_RING, 1, 1, 0, 0);
`ifdef ALARM_TRIGGER_SNOOZE_EN
    applyStimulus(1, 0, 1, 0, 1, hms(23, 58, 10));
    checkOutput("snooze1", S_SNZ, 0, 0, 1, 0);
    alm_t = hms(12, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(11, 59, 59));
    applyStimulus(1, 1, 1, 0, 0, hms(12, 0, 0));
    checkOutput("alm_change_ignored", S_SNZ, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(0, 3, 9));
    applyStimulus(1, 1, 1, 0, 0, hms(0, 3, 10));
    checkOutput("snooze1_ring", S_RING, 1, 1, 1, 0);
    applyStimulus(1, 0, 1, 0, 1, hms(0, 3, 10));
    checkOutput("snooze2", S_SNZ, 0, 0, 2, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(0, 8, 9));
    applyStimulus(1, 1, 1, 0, 0, hms(0, 8, 10));
    checkOutput("snooze2_ring", S_RING, 1, 1, 2, 0);
    applyStimulus(1, 0, 1, 0, 1, hms(0, 8, 10));
    checkOutput("snooze3", S_SNZ, 0, 0, 3, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(0, 13, 9));
    applyStimulus(1, 1, 1, 0, 0, hms(0, 13, 10));
    checkOutput("snooze3_ring", S_RING, 1, 1, 3, 0);
    applyStimulus(1, 0, 1, 0, 1, hms(0, 13, 10));
    checkOutput("snooze4_ignored", S_RING, 1, 1, 3, 0);
    applyStimulus(1, 0, 1, 1, 1, hms(0, 13, 10));
    checkOutput("ack_snooze_together", S_ARMED, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, hms(11, 59, 59));
    applyStimulus(1, 0, 1, 0, 0, hms(12, 0, 0));
    checkOutput("ring6_entry", S_RING, 1, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 1, hms(12, 0, 0));
    checkOutput("snooze_again", S_SNZ, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, hms(12, 0, 0));
    checkOutput("disarm_snoozed", S_IDLE, 0, 0, 0, 0);
`else
    applyStimulus(1, 0, 1, 0, 1, hms(23, 58, 10));
    checkOutput("snooze_ignored", S_RING, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 1, hms(23, 58, 11));
    checkOutput("snooze_ignored_tick", S_RING, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 1, hms(23, 58, 11));
    checkOutput("ack_snooze_together", S_ARMED, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, hms(0, 3, 9));
    applyStimulus(1, 1, 1, 0, 0, hms(0, 3, 10));
    checkOutput("no_snooze_ring", S_ARMED, 0, 0, 0, 0);
`endif

    repeat (3) @(negedge CLK);
    done = 1'b1;
  end

endmodule

// File: doc/alarm_trigger.md
ALARM_TRIGGER -- requirements
Module: alarm_trigger

Interface
REQ-001 Parameter SNOOZE_MIN, 5, minutes added to the ring time on each snooze (range 1..59).
REQ-002 Parameter RING_TIMEOUT, 60, SEC_TICK count after which an unacknowledged ring self-cancels (range 1..255).
REQ-003 Parameter MAX_SNOOZE, 3, maximum snoozes per alarm event (range 1..3).
REQ-004 Port CLK  input  1  system clock; all state updates on its rising edge.
REQ-005 Port RESET  input  1  reset, synchronous, active-low.
REQ-006 Port SEC_TICK  input  1  one-cycle pulse once per second, coincident with the current-time update.
REQ-007 Port CUR_SEC, CUR_MIN, CUR_HR  input  8 each  current time, binary (0..59, 0..59, 0..23).
REQ-008 Port ALM_SEC, ALM_MIN, ALM_HR  input  8 each  programmed alarm time, binary, same ranges.
REQ-009 Port ARM  input  1  level; 1 = alarm enabled.
REQ-010 Port ACK  input  1  level, synchronous; dismiss the ringing alarm.
REQ-011 Port SNOOZE  input  1  level, synchronous; request a snooze.
REQ-012 Port ALARM  output  1  high while in RINGING.
REQ-013 Port BEEP  output  1  buzzer drive; toggles once per second while ringing.
REQ-014 Port STATE  output  2  00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZED.
REQ-015 Port SNOOZE_CNT  output  2  number of snoozes taken in the current alarm event.
REQ-016 Port MISSED  output  1  sticky; set when a ring times out.

Function
REQ-017 The block SHALL compute a one-cycle match pulse on the rising edge of (CUR == target), comparing all three fields; a match held for a whole second SHALL trigger only once.
REQ-018 In ARMED the target SHALL equal the ALM_* inputs on every cycle.
REQ-019 IDLE->ARMED SHALL occur on the first cycle ARM=1; ARM=0 in any state SHALL force IDLE next cycle and clear SNOOZE_CNT; ALARM, BEEP, and the ring counter SHALL also clear.
REQ-020 ARMED->RINGING SHALL occur on the cycle after a match pulse; BEEP=1 and the ring counter=0 on entry.
REQ-021 In RINGING, each SEC_TICK SHALL toggle BEEP and increment the ring counter.
REQ-022 ACK=1 in RINGING SHALL give ARMED next cycle, with SNOOZE_CNT=0 and MISSED=0.
REQ-023 SNOOZE=1 (ACK=0) in RINGING with SNOOZE_CNT<MAX_SNOOZE SHALL give SNOOZED, increment SNOOZE_CNT, and load the snooze target.
REQ-024 SNOOZE in RINGING with SNOOZE_CNT=MAX_SNOOZE SHALL be ignored.
REQ-025 ACK and SNOOZE asserted together SHALL be treated as ACK.
REQ-026 Snooze target: sec = CUR_SEC; min = CUR_MIN+SNOOZE_MIN, minus 60 with hour carry if >=60; hr += carry, 24 wraps to 0 (e.g. 23:58:10 +5 -> 00:03:10).
REQ-027 When the ring counter reaches RING_TIMEOUT, the block SHALL go to ARMED, set MISSED=1, and clear SNOOZE_CNT.
REQ-028 SNOOZED->RINGING SHALL occur on a match pulse against the snooze target; ACK in SNOOZED SHALL give ARMED with SNOOZE_CNT=0.
REQ-029 ALM_* changes in SNOOZED SHALL NOT alter the snooze target.
REQ-030 All outputs SHALL be registered; STATE reflects the current state with one-cycle latency from the causing input.

Reset
REQ-031 RESET=0 sampled at a CLK edge SHALL set state IDLE, ALARM=0, BEEP=0, SNOOZE_CNT=0, MISSED=0, ring counter=0, target=0, and the match history to "matched" so no spurious pulse follows reset.
REQ-032 Reset SHALL take priority over all other inputs, including mid-ring.

Configuration
REQ-033 Macro ALARM_TRIGGER_SNOOZE_EN: when defined, the snooze logic of REQ-023..029 SHALL be built.
REQ-034 When ALARM_TRIGGER_SNOOZE_EN is undefined, SNOOZE SHALL be ignored, SNOOZED SHALL be unreachable, SNOOZE_CNT SHALL be tied 0, and no snooze target register SHALL exist.

Verification
REQ-035 ARM=1, ALM=07:00:00, CUR steps 06:59:59->07:00:00 -> ALARM=1 and STATE=10 one cycle later; BEEP toggles 1,0,1 over 3 ticks.
REQ-036 Ringing, ACK pulse -> STATE=01 and ALARM=0 next cycle; CUR held at 07:00:00 for the rest of the second -> no re-trigger.
REQ-037 Ringing at 23:58:10, SNOOZE (macro on) -> STATE=11, SNOOZE_CNT=1; CUR reaches 00:03:10 -> STATE=10; after 3 snoozes a 4th SNOOZE is ignored.
REQ-038 Ringing with no input for 60 SEC_TICKs -> STATE=01, MISSED=1; a later ACK clears MISSED.
REQ-039 RESET=0 mid-ring -> all outputs 0 and STATE=00 next cycle; ARM=0 during SNOOZED -> STATE=00 and SNOOZE_CNT=0.
